// File: rtl/audio_serial_bit_sequencer.sv
// -----------------------------------------------------------------------------
// audio_serial_bit_sequencer
// Turns BCLK/LRCLK edge strobes into per-bit sample strobes for the serial
// audio shift registers. Supports I2S, left-justified and right-justified
// framing for word lengths of 1..32 bits.
//
// Ports
//   clk                          system clock, rising edge
//   reset                        synchronous active-high reset
//   bit_clk_rising_edge          one-cycle pulse per BCLK rising edge
//   bit_clk_falling_edge         one-cycle pulse per BCLK falling edge
//   left_right_clk_rising_edge   one-cycle pulse, starts a right-channel word
//   left_right_clk_falling_edge  one-cycle pulse, starts a left-channel word
//   mode                         0 I2S, 1 left-justified, 2 right-justified, 3 I2S
//   counting                     high from word start until the last bit is sampled
//   channel                      0 left, 1 right (current or last word)
//   bit_index                    MSB-first index of the bit being sampled
//   shift_strobe                 sample/shift the bit at bit_index
//   word_done                    pulses with the final shift_strobe of a word
//   frame_error                  pulses when an LR edge truncates a running word
// -----------------------------------------------------------------------------
module audio_serial_bit_sequencer #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned SLOT_BITS  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bit_clk_rising_edge,
   input  logic       bit_clk_falling_edge,
   input  logic       left_right_clk_rising_edge,
   input  logic       left_right_clk_falling_edge,
   input  logic [1:0] mode,
   output logic       counting,
   output logic       channel,
   output logic [5:0] bit_index,
   output logic       shift_strobe,
   output logic       word_done,
   output logic       frame_error
);

   localparam int unsigned IDX_W   = 6;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned RJ_SKIP = (DATA_WIDTH >= SLOT_BITS) ? 0 : (SLOT_BITS - DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] skip_cnt, skip_cnt_d;
   logic             strobed, strobed_d;
   logic             counting_d, channel_d;
   logic [IDX_W-1:0] bit_index_d;
   logic             shift_strobe_d, word_done_d, frame_error_d;
   logic             lr_edge;
   logic [CNT_W-1:0] start_skip;

   assign lr_edge = left_right_clk_rising_edge | left_right_clk_falling_edge;

   // Falling BCLK edges to wait between the LR edge and the MSB.
   always_comb begin
      start_skip = CNT_W'(1);
      case (mode)
         2'd1:    start_skip = '0;
         2'd2:    start_skip = CNT_W'(RJ_SKIP);
         default: start_skip = CNT_W'(1);
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         skip_cnt     <= '0;
         strobed      <= 1'b0;
         counting     <= 1'b0;
         channel      <= 1'b0;
         bit_index    <= '0;
         shift_strobe <= 1'b0;
         word_done    <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         state        <= state_d;
         skip_cnt     <= skip_cnt_d;
         strobed      <= strobed_d;
         counting     <= counting_d;
         channel      <= channel_d;
         bit_index    <= bit_index_d;
         shift_strobe <= shift_strobe_d;
         word_done    <= word_done_d;
         frame_error  <= frame_error_d;
      end
   end

   // Next-state and next-output logic; LR edges override BCLK activity.
   always_comb begin
      state_d        = state;
      skip_cnt_d     = skip_cnt;
      strobed_d      = strobed;
      counting_d     = counting;
      channel_d      = channel;
      bit_index_d    = bit_index;
      shift_strobe_d = 1'b0;
      word_done_d    = 1'b0;
      frame_error_d  = 1'b0;

      if (lr_edge) begin
         // Mode only matters here, so mid-word mode changes have no effect.
         channel_d     = left_right_clk_rising_edge;
         bit_index_d   = IDX_W'(DATA_WIDTH - 1);
         counting_d    = 1'b1;
         frame_error_d = counting;
         strobed_d     = 1'b0;
         skip_cnt_d    = start_skip;
         state_d       = (start_skip == '0) ? SHIFT : DELAY;
      end else begin
         case (state)
            DELAY: begin
               if (bit_clk_falling_edge) begin
                  skip_cnt_d = skip_cnt - CNT_W'(1);
                  if (skip_cnt == CNT_W'(1)) begin
                     state_d = SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (bit_clk_rising_edge) begin
                  shift_strobe_d = 1'b1;
                  strobed_d      = 1'b1;
                  if (bit_index == '0) begin
                     word_done_d = 1'b1;
                     counting_d  = 1'b0;
                     state_d     = IDLE;
                  end
               end else if (bit_clk_falling_edge && strobed) begin
                  // Advance only once the current bit has been sampled.
                  bit_index_d = bit_index - IDX_W'(1);
                  strobed_d   = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_serial_bit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_serial_bit_sequencer
// Drives three sequencer instances (24/16/32-bit words, 32-bit slots) with the
// same edge strobes and compares every output each cycle against a word-level
// reference model, then runs randomized traffic.
// -----------------------------------------------------------------------------
module tb_audio_serial_bit_sequencer;

   localparam int NI   = 3;
   localparam int SLOT = 32;

   logic       clk;
   logic       reset;
   logic       bit_clk_rising_edge;
   logic       bit_clk_falling_edge;
   logic       left_right_clk_rising_edge;
   logic       left_right_clk_falling_edge;
   logic [1:0] mode;

   logic [NI-1:0] cnt_w, ch_w, ss_w, wd_w, fe_w;
   logic [5:0]    idx_w [NI];

   audio_serial_bit_sequencer #(.DATA_WIDTH(24), .SLOT_BITS(SLOT)) u0 (
      .clk(clk), .reset(reset),
      .bit_clk_rising_edge(bit_clk_rising_edge), .bit_clk_falling_edge(bit_clk_falling_edge),
      .left_right_clk_rising_edge(left_right_clk_rising_edge),
      .left_right_clk_falling_edge(left_right_clk_falling_edge),
      .mode(mode), .counting(cnt_w[0]), .channel(ch_w[0]), .bit_index(idx_w[0]),
      .shift_strobe(ss_w[0]), .word_done(wd_w[0]), .frame_error(fe_w[0]));

   audio_serial_bit_sequencer #(.DATA_WIDTH(16), .SLOT_BITS(SLOT)) u1 (
      .clk(clk), .reset(reset),
      .bit_clk_rising_edge(bit_clk_rising_edge), .bit_clk_falling_edge(bit_clk_falling_edge),
      .left_right_clk_rising_edge(left_right_clk_rising_edge),
      .left_right_clk_falling_edge(left_right_clk_falling_edge),
      .mode(mode), .counting(cnt_w[1]), .channel(ch_w[1]), .bit_index(idx_w[1]),
      .shift_strobe(ss_w[1]), .word_done(wd_w[1]), .frame_error(fe_w[1]));

   audio_serial_bit_sequencer #(.DATA_WIDTH(32), .SLOT_BITS(SLOT)) u2 (
      .clk(clk), .reset(reset),
      .bit_clk_rising_edge(bit_clk_rising_edge), .bit_clk_falling_edge(bit_clk_falling_edge),
      .left_right_clk_rising_edge(left_right_clk_rising_edge),
      .left_right_clk_falling_edge(left_right_clk_falling_edge),
      .mode(mode), .counting(cnt_w[2]), .channel(ch_w[2]), .bit_index(idx_w[2]),
      .shift_strobe(ss_w[2]), .word_done(wd_w[2]), .frame_error(fe_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: per instance, expected outputs plus the falling edges
   // still to wait before the MSB and whether the current bit was sampled.
   logic e_cnt [NI];
   logic e_ch  [NI];
   int   e_idx [NI];
   logic e_ss  [NI];
   logic e_wd  [NI];
   logic e_fe  [NI];
   int   m_wait[NI];
   logic m_hit [NI];

   // Observed pulse tallies for directed checks.
   int n_ss [NI];
   int n_wd [NI];
   int n_fe [NI];

   logic [1:0] cur_mode = 2'd1;

   function automatic int dw_of(input int i);
      case (i)
         0:       return 24;
         1:       return 16;
         default: return 32;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_step(input int i);
      int w;
      int skip;
      w = dw_of(i);
      e_ss[i] = 1'b0;
      e_wd[i] = 1'b0;
      e_fe[i] = 1'b0;
      if (reset) begin
         e_cnt[i] = 1'b0; e_ch[i] = 1'b0; e_idx[i] = 0; m_wait[i] = 0; m_hit[i] = 1'b0;
      end else if (left_right_clk_rising_edge || left_right_clk_falling_edge) begin
         case (mode)
            2'd1:    skip = 0;
            2'd2:    skip = (w >= SLOT) ? 0 : SLOT - w;
            default: skip = 1;
         endcase
         e_fe[i]   = e_cnt[i];
         e_ch[i]   = left_right_clk_rising_edge;
         e_idx[i]  = w - 1;
         e_cnt[i]  = 1'b1;
         m_wait[i] = skip;
         m_hit[i]  = 1'b0;
      end else if (e_cnt[i]) begin
         if (m_wait[i] != 0) begin
            if (bit_clk_falling_edge) m_wait[i]--;
         end else if (bit_clk_rising_edge) begin
            e_ss[i]  = 1'b1;
            m_hit[i] = 1'b1;
            if (e_idx[i] == 0) begin
               e_wd[i]  = 1'b1;
               e_cnt[i] = 1'b0;
            end
         end else if (bit_clk_falling_edge && m_hit[i]) begin
            e_idx[i]--;
            m_hit[i] = 1'b0;
         end
      end
   endtask

   task automatic tick(input logic rst, input logic lrr, input logic lrf,
                       input logic br, input logic bf);
      reset                       = rst;
      left_right_clk_rising_edge  = lrr;
      left_right_clk_falling_edge = lrf;
      bit_clk_rising_edge         = br;
      bit_clk_falling_edge        = bf;
      mode                        = cur_mode;
      for (int i = 0; i < NI; i++) model_step(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("u%0d.counting", i),     32'(cnt_w[i]), 32'(e_cnt[i]));
         check($sformatf("u%0d.channel", i),      32'(ch_w[i]),  32'(e_ch[i]));
         check($sformatf("u%0d.bit_index", i),    32'(idx_w[i]), 32'(e_idx[i]));
         check($sformatf("u%0d.shift_strobe", i), 32'(ss_w[i]),  32'(e_ss[i]));
         check($sformatf("u%0d.word_done", i),    32'(wd_w[i]),  32'(e_wd[i]));
         check($sformatf("u%0d.frame_error", i),  32'(fe_w[i]),  32'(e_fe[i]));
         if (ss_w[i] === 1'b1) n_ss[i]++;
         if (wd_w[i] === 1'b1) n_wd[i]++;
         if (fe_w[i] === 1'b1) n_fe[i]++;
      end
   endtask

   task automatic clear_tallies();
      for (int i = 0; i < NI; i++) begin
         n_ss[i] = 0; n_wd[i] = 0; n_fe[i] = 0;
      end
   endtask

   // One full BCLK period: rise, gap, fall, gap.
   task automatic bclk_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1;
      bit_clk_rising_edge = 1'b0;
      bit_clk_falling_edge = 1'b0;
      left_right_clk_rising_edge = 1'b0;
      left_right_clk_falling_edge = 1'b0;
      mode = 2'd0;

      // Reset state.
      repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.bit_index", 32'(idx_w[0]), 32'd0);
      check("reset.counting", 32'(cnt_w[0]), 32'd0);

      // Left-justified, left channel.
      cur_mode = 2'd1;
      clear_tallies();
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("lj.start_index", 32'(idx_w[0]), 32'd23);
      bclk_cycles(26);
      check("lj.strobes", 32'(n_ss[0]), 32'd24);
      check("lj.done", 32'(n_wd[0]), 32'd1);
      check("lj.strobes16", 32'(n_ss[1]), 32'd16);

      // I2S, right channel: first rising edge precedes the delay falling edge.
      cur_mode = 2'd0;
      clear_tallies();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("i2s.no_early_strobe", 32'(n_ss[1]), 32'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bclk_cycles(26);
      check("i2s.strobes16", 32'(n_ss[1]), 32'd16);
      check("i2s.channel", 32'(ch_w[1]), 32'd1);

      // Right-justified: 8 idle falling edges for 24 bits, none for 32 bits.
      cur_mode = 2'd2;
      clear_tallies();
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bclk_cycles(8);
      check("rj.skip_u0", 32'(n_ss[0]), 32'd0);
      check("rj.noskip_u2", 32'(n_ss[2]), 32'd8);
      bclk_cycles(28);
      check("rj.strobes_u0", 32'(n_ss[0]), 32'd24);
      check("rj.done_u0", 32'(n_wd[0]), 32'd1);
      check("rj.strobes_u2", 32'(n_ss[2]), 32'd32);

      // Truncated word: LR edge after 10 bits.
      cur_mode = 2'd1;
      clear_tallies();
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bclk_cycles(10);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("trunc.error", 32'(fe_w[0]), 32'd1);
      check("trunc.restart_index", 32'(idx_w[0]), 32'd23);
      bclk_cycles(26);
      check("trunc.one_done", 32'(n_wd[0]), 32'd1);

      // Reset mid-word, then BCLK alone must not strobe.
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bclk_cycles(5);
      clear_tallies();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bclk_cycles(10);
      check("rst.no_strobes", 32'(n_ss[0]), 32'd0);
      check("rst.no_done", 32'(n_wd[0] + n_fe[0]), 32'd0);

      // Mode changed mid-word and mode 3 framing.
      cur_mode = 2'd0;
      clear_tallies();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cur_mode = 2'd1;
      bclk_cycles(3);
      cur_mode = 2'd2;
      bclk_cycles(24);
      check("mode.latched", 32'(n_ss[0]), 32'd24);
      cur_mode = 2'd3;
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bclk_cycles(26);

      // Randomized traffic, including illegal simultaneous edges.
      for (int k = 0; k < 6000; k++) begin
         logic rr, lr, lf, br, bf;
         rr = ($urandom_range(0, 299) == 0);
         lr = ($urandom_range(0, 79) == 0);
         lf = ($urandom_range(0, 79) == 0);
         br = ($urandom_range(0, 3) == 0);
         bf = ($urandom_range(0, 3) == 0);
         cur_mode = 2'($urandom_range(0, 3));
         tick(rr, lr, lf, br, bf);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
